// File: rtl/branch_predictor_if.sv
// Fetch-lookup and EX-training signals of the branch predictor.
// The predictor takes the slave side; fetch/EX logic (or a bench) takes the master side.
interface branch_predictor_if #(
  parameter int XLEN     = 32,
  parameter int VPC_BITS = 32
);
  logic [VPC_BITS-1:0] F_pc;
  logic                F_BP_taken;
  logic [VPC_BITS-1:0] F_BP_target_pc;
  logic                EX_valid;
  logic                EX_brn;
  logic [VPC_BITS-1:0] EX_pc;
  logic                EX_true_taken;
  logic [XLEN-1:0]     EX_alu_out;
  logic                EX_taken;
  logic                BP_flush_all;
  logic [31:0]         BP_lookups;
  logic [31:0]         BP_mispredicts;

  modport master (
    output F_pc, EX_valid, EX_brn, EX_pc, EX_true_taken, EX_alu_out, EX_taken, BP_flush_all,
    input  F_BP_taken, F_BP_target_pc, BP_lookups, BP_mispredicts
  );
  modport slave (
    input  F_pc, EX_valid, EX_brn, EX_pc, EX_true_taken, EX_alu_out, EX_taken, BP_flush_all,
    output F_BP_taken, F_BP_target_pc, BP_lookups, BP_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit saturating counter per entry, combinational
// fetch-side lookup, edge-trained from EX, plus saturating perf counters.

module bp_entry #(
  parameter int TAG_BITS = 26,
  parameter int VPC_BITS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_flush,
  input  logic                i_upd,
  input  logic                i_taken,
  input  logic [TAG_BITS-1:0] i_tag,
  input  logic [VPC_BITS-1:0] i_target,
  output logic                o_valid,
  output logic [TAG_BITS-1:0] o_tag,
  output logic [VPC_BITS-1:0] o_target,
  output logic [1:0]          o_ctr
);
  logic                r_valid;
  logic [TAG_BITS-1:0] r_tag;
  logic [VPC_BITS-1:0] r_target;
  logic [1:0]          r_ctr;
  logic                w_hit;

  assign w_hit = r_valid && (r_tag == i_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_tag    <= '0;
      r_target <= '0;
      r_ctr    <= 2'b01;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_upd) begin
      if (w_hit) begin
        if (i_taken) begin
          r_ctr    <= (r_ctr == 2'b11) ? 2'b11 : r_ctr + 2'b01;
          r_target <= i_target;
        end else begin
          r_ctr <= (r_ctr == 2'b00) ? 2'b00 : r_ctr - 2'b01;
        end
      end else if (i_taken) begin
        // Only taken branches allocate; a not-taken miss leaves the slot alone.
        r_valid  <= 1'b1;
        r_tag    <= i_tag;
        r_target <= i_target;
        r_ctr    <= 2'b10;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_tag    = r_tag;
  assign o_target = r_target;
  assign o_ctr    = r_ctr;
endmodule

module branch_predictor #(
  parameter int XLEN     = 32,
  parameter int VPC_BITS = 32,
  parameter int IDX_BITS = 4
) (
  input logic clk,
  input logic rst_n,
  branch_predictor_if.slave bp
);
  localparam int TAG_BITS = VPC_BITS - IDX_BITS - 2;
  localparam int ENTRIES  = 1 << IDX_BITS;

  logic [IDX_BITS-1:0]                  w_f_idx, w_ex_idx;
  logic [TAG_BITS-1:0]                  w_f_tag, w_ex_tag;
  logic [ENTRIES-1:0]                   w_valid;
  logic [ENTRIES-1:0][TAG_BITS-1:0]     w_tag;
  logic [ENTRIES-1:0][VPC_BITS-1:0]     w_target;
  logic [ENTRIES-1:0][1:0]              w_ctr;
  logic                                 w_upd, w_hit;
  logic                                 w_unused;
  logic [31:0]                          r_lookups, r_mispredicts;

  assign w_f_idx  = bp.F_pc[IDX_BITS+1:2];
  assign w_f_tag  = bp.F_pc[VPC_BITS-1:IDX_BITS+2];
  assign w_ex_idx = bp.EX_pc[IDX_BITS+1:2];
  assign w_ex_tag = bp.EX_pc[VPC_BITS-1:IDX_BITS+2];
  assign w_upd    = bp.EX_valid && bp.EX_brn;
  assign w_unused = ^{bp.F_pc[1:0], bp.EX_pc[1:0]};

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    bp_entry #(.TAG_BITS(TAG_BITS), .VPC_BITS(VPC_BITS)) u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_flush  (bp.BP_flush_all),
      .i_upd    (w_upd && (w_ex_idx == IDX_BITS'(g))),
      .i_taken  (bp.EX_true_taken),
      .i_tag    (w_ex_tag),
      .i_target (bp.EX_alu_out[VPC_BITS-1:0]),
      .o_valid  (w_valid[g]),
      .o_tag    (w_tag[g]),
      .o_target (w_target[g]),
      .o_ctr    (w_ctr[g])
    );
  end

  // Lookup sees registered table state only, so a same-cycle update shows up next cycle.
  assign w_hit             = w_valid[w_f_idx] && (w_tag[w_f_idx] == w_f_tag);
  assign bp.F_BP_taken     = w_hit && w_ctr[w_f_idx][1];
  assign bp.F_BP_target_pc = bp.F_BP_taken ? w_target[w_f_idx] : bp.F_pc + VPC_BITS'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lookups     <= '0;
      r_mispredicts <= '0;
    end else begin
      if (r_lookups != 32'hFFFF_FFFF) r_lookups <= r_lookups + 32'd1;
      if (w_upd && bp.EX_taken && (r_mispredicts != 32'hFFFF_FFFF))
        r_mispredicts <= r_mispredicts + 32'd1;
    end
  end

  assign bp.BP_lookups     = r_lookups;
  assign bp.BP_mispredicts = r_mispredicts;
endmodule
